// File: rtl/escalonador_interrupcoes.sv
// Interrupt controller and preemption scheduler: quantum timer, halt/timer/key
// arbitration, PC redirect to the kernel vector and return to the saved PC.
module escalonador_interrupcoes #(
    parameter int              PC_W    = 11,
    parameter int              TIMER_W = 16,
    parameter logic [PC_W-1:0] VECTOR  = '0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Halt,
    input  logic               SetClock,
    input  logic [TIMER_W-1:0] Quantum,
    input  logic               KeyReady,
    input  logic               MaskWrite,
    input  logic [1:0]         MaskData,
    input  logic               GetInterruption,
    input  logic               Resume,
    input  logic [PC_W-1:0]    NextPC,
    output logic               Redirect,
    output logic [PC_W-1:0]    TargetPC,
    output logic [PC_W-1:0]    SavedPC,
    output logic [31:0]        Cause,
    output logic               InService,
    output logic [TIMER_W-1:0] TimerCount
);

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         pending_q, pending_d;
    logic [1:0]         mask_q, mask_d;
    logic [TIMER_W-1:0] reload_q, reload_d;
    logic [TIMER_W-1:0] count_q, count_d;
    logic               armed_q, armed_d;
    logic [PC_W-1:0]    saved_pc_q, saved_pc_d;
    logic [1:0]         cause_q, cause_d;

    logic [2:0] ev;
    logic [2:0] elig;
    logic [2:0] win_bit;
    logic [1:0] win_code;
    logic       in_idle;
    logic       dispatch;
    logic       resume_now;

    // Arbitration: halt (bit 2) > timer (bit 0) > key (bit 1)
    always_comb begin
        ev         = pending_q | {Halt, KeyReady, 1'b0};
        elig       = {ev[2], ev[1] & mask_q[1], ev[0] & mask_q[0]};
        in_idle    = (state_q == IDLE);
        dispatch   = in_idle && (elig != 3'b000);
        resume_now = (state_q == SERVICE) && Resume;
        win_bit    = 3'b010;
        win_code   = 2'd3;
        if (elig[2]) begin
            win_bit  = 3'b100;
            win_code = 2'd2;
        end else if (elig[0]) begin
            win_bit  = 3'b001;
            win_code = 2'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = ev;
        mask_d     = mask_q;
        reload_d   = reload_q;
        count_d    = count_q;
        armed_d    = armed_q;
        saved_pc_d = saved_pc_q;
        cause_d    = cause_q;

        if (MaskWrite) begin
            mask_d = MaskData;
        end

        if (dispatch) begin
            state_d    = SERVICE;
            saved_pc_d = NextPC;
            cause_d    = win_code;
            pending_d  = ev & ~win_bit;
        end

        if (state_q == SERVICE) begin
            if (GetInterruption) begin
                cause_d = 2'd0;
            end
            if (Resume) begin
                state_d = IDLE;
            end
        end

        // Expiry still fires on a dispatch cycle so the timer stays pending behind a halt
        if (SetClock) begin
            reload_d = Quantum;
            count_d  = Quantum;
            armed_d  = (Quantum != '0);
        end else if (in_idle && armed_q) begin
            if (count_q == TIMER_W'(1)) begin
                pending_d[0] = 1'b1;
                count_d      = reload_q;
            end else if (!dispatch && count_q != '0) begin
                count_d = count_q - TIMER_W'(1);
            end
        end else if (resume_now && armed_q) begin
            count_d = reload_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q    <= IDLE;
            pending_q  <= 3'b000;
            mask_q     <= 2'b11;
            reload_q   <= '0;
            count_q    <= '0;
            armed_q    <= 1'b0;
            saved_pc_q <= '0;
            cause_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            armed_q    <= armed_d;
            saved_pc_q <= saved_pc_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        Redirect   = dispatch || resume_now;
        TargetPC   = resume_now ? saved_pc_q : VECTOR;
        SavedPC    = saved_pc_q;
        Cause      = {30'd0, cause_q};
        InService  = (state_q == SERVICE);
        TimerCount = count_q;
    end

endmodule

// File: tb/tb_escalonador_interrupcoes.sv
// Scoreboard bench for escalonador_interrupcoes: directed cycles push expected
// output values; a negedge monitor pops and compares them.
module tb_escalonador_interrupcoes;

    localparam int PC_W    = 11;
    localparam int TIMER_W = 16;

    localparam int F_REDIRECT = 0;
    localparam int F_TARGET   = 1;
    localparam int F_SAVED    = 2;
    localparam int F_CAUSE    = 3;
    localparam int F_INSVC    = 4;
    localparam int F_COUNT    = 5;

    logic               Clock;
    logic               Reset;
    logic               Halt;
    logic               SetClock;
    logic [TIMER_W-1:0] Quantum;
    logic               KeyReady;
    logic               MaskWrite;
    logic [1:0]         MaskData;
    logic               GetInterruption;
    logic               Resume;
    logic [PC_W-1:0]    NextPC;
    logic               Redirect;
    logic [PC_W-1:0]    TargetPC;
    logic [PC_W-1:0]    SavedPC;
    logic [31:0]        Cause;
    logic               InService;
    logic [TIMER_W-1:0] TimerCount;

    typedef struct {
        string       name;
        int          fld;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    escalonador_interrupcoes #(
        .PC_W   (PC_W),
        .TIMER_W(TIMER_W),
        .VECTOR (11'd0)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Halt           (Halt),
        .SetClock       (SetClock),
        .Quantum        (Quantum),
        .KeyReady       (KeyReady),
        .MaskWrite      (MaskWrite),
        .MaskData       (MaskData),
        .GetInterruption(GetInterruption),
        .Resume         (Resume),
        .NextPC         (NextPC),
        .Redirect       (Redirect),
        .TargetPC       (TargetPC),
        .SavedPC        (SavedPC),
        .Cause          (Cause),
        .InService      (InService),
        .TimerCount     (TimerCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [31:0] actual(input int fld);
        case (fld)
            F_REDIRECT: return {31'd0, Redirect};
            F_TARGET:   return {21'd0, TargetPC};
            F_SAVED:    return {21'd0, SavedPC};
            F_CAUSE:    return Cause;
            F_INSVC:    return {31'd0, InService};
            default:    return {16'd0, TimerCount};
        endcase
    endfunction

    always @(negedge Clock) begin
        chk_t        c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c   = sb.pop_front();
            act = actual(c.fld);
            n_vec++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d required %0d (t=%0t)", c.name, act, c.exp, $time);
            end
        end
    end

    task automatic chk(input string name, input int fld, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.fld  = fld;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        Halt            = 1'b0;
        SetClock        = 1'b0;
        KeyReady        = 1'b0;
        MaskWrite       = 1'b0;
        GetInterruption = 1'b0;
        Resume          = 1'b0;
    endtask

    initial begin
        Reset           = 1'b0;
        Halt            = 1'b0;
        SetClock        = 1'b0;
        Quantum         = '0;
        KeyReady        = 1'b0;
        MaskWrite       = 1'b0;
        MaskData        = 2'b00;
        GetInterruption = 1'b0;
        Resume          = 1'b0;
        NextPC          = '0;
        tick();
        tick();

        chk("rst_redirect", F_REDIRECT, 0);
        chk("rst_insvc",    F_INSVC,    0);
        chk("rst_cause",    F_CAUSE,    0);
        chk("rst_count",    F_COUNT,    0);
        chk("rst_saved",    F_SAVED,    0);
        Reset = 1'b1;
        tick();

        // Quantum 5: count 5,4,3,2,1 then expiry and dispatch
        SetClock = 1'b1;
        Quantum  = 16'd5;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("tmr_count", F_COUNT, 32'(5 - i));
            chk("tmr_noredir", F_REDIRECT, 0);
            tick();
        end
        NextPC = 11'd100;
        chk("tmr_redirect", F_REDIRECT, 1);
        chk("tmr_target",   F_TARGET,   0);
        chk("tmr_reload",   F_COUNT,    5);
        tick();
        chk("tmr_saved", F_SAVED,    100);
        chk("tmr_cause", F_CAUSE,    1);
        chk("tmr_insvc", F_INSVC,    1);
        chk("svc_noredir", F_REDIRECT, 0);

        // In service: key only latches, timer frozen
        KeyReady = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("svc_frozen",  F_COUNT,    5);
            chk("svc_noredir", F_REDIRECT, 0);
            chk("svc_insvc",   F_INSVC,    1);
            tick();
        end
        GetInterruption = 1'b1;
        chk("getint_prior", F_CAUSE, 1);
        tick();
        chk("getint_clear", F_CAUSE, 0);
        Resume = 1'b1;
        NextPC = 11'd50;
        chk("resume_redirect", F_REDIRECT, 1);
        chk("resume_target",   F_TARGET,   100);
        tick();
        NextPC = 11'd101;
        chk("key_redirect", F_REDIRECT, 1);
        chk("key_target",   F_TARGET,   0);
        chk("key_idle",     F_INSVC,    0);
        tick();
        chk("key_cause", F_CAUSE, 3);
        chk("key_saved", F_SAVED, 101);
        Resume = 1'b1;
        chk("key_ret_target", F_TARGET, 101);
        tick();

        // Halt together with timer expiry: halt first, timer after return
        for (int i = 0; i < 4; i++) begin
            chk("ht_count", F_COUNT, 32'(5 - i));
            chk("ht_noredir", F_REDIRECT, 0);
            tick();
        end
        Halt   = 1'b1;
        NextPC = 11'd200;
        chk("ht_redirect", F_REDIRECT, 1);
        chk("ht_count1",   F_COUNT,    1);
        tick();
        chk("ht_cause",  F_CAUSE, 2);
        chk("ht_saved",  F_SAVED, 200);
        chk("ht_reload", F_COUNT, 5);
        Resume          = 1'b1;
        GetInterruption = 1'b1;
        chk("ht_ret_redirect", F_REDIRECT, 1);
        chk("ht_ret_target",   F_TARGET,   200);
        chk("ht_ret_cause",    F_CAUSE,    2);
        tick();
        NextPC = 11'd201;
        chk("ht_tmr_redirect", F_REDIRECT, 1);
        chk("ht_tmr_target",   F_TARGET,   0);
        chk("ht_cause_cleared", F_CAUSE,   0);
        tick();
        chk("ht_tmr_cause", F_CAUSE, 1);
        chk("ht_tmr_saved", F_SAVED, 201);
        Resume = 1'b1;
        tick();

        Resume = 1'b1;
        chk("idle_resume_ignored", F_REDIRECT, 0);
        chk("idle_resume_insvc",   F_INSVC,    0);
        tick();
        SetClock = 1'b1;
        Quantum  = 16'd0;
        tick();
        chk("q0_count", F_COUNT, 0);

        // Key masked off: latches without dispatch until re-enabled
        MaskWrite = 1'b1;
        MaskData  = 2'b01;
        tick();
        KeyReady = 1'b1;
        chk("mask_noredir", F_REDIRECT, 0);
        tick();
        chk("mask_noredir2", F_REDIRECT, 0);
        chk("mask_idle",     F_INSVC,    0);
        tick();
        MaskWrite = 1'b1;
        MaskData  = 2'b11;
        chk("mask_write_cycle", F_REDIRECT, 0);
        tick();
        NextPC = 11'd300;
        chk("unmask_redirect", F_REDIRECT, 1);
        chk("unmask_target",   F_TARGET,   0);
        tick();
        chk("unmask_cause", F_CAUSE, 3);
        chk("unmask_saved", F_SAVED, 300);
        Resume = 1'b1;
        tick();

        for (int i = 0; i < 1000; i++) begin
            chk("q0_noredir", F_REDIRECT, 0);
            chk("q0_frozen",  F_COUNT,    0);
            tick();
        end

        // Reset in service with timer and key pending
        SetClock = 1'b1;
        Quantum  = 16'd3;
        tick();
        chk("q3_count", F_COUNT, 3);
        tick();
        tick();
        Halt   = 1'b1;
        NextPC = 11'd400;
        chk("rs_redirect", F_REDIRECT, 1);
        chk("rs_count1",   F_COUNT,    1);
        tick();
        KeyReady = 1'b1;
        chk("rs_insvc",   F_INSVC,    1);
        chk("rs_noredir", F_REDIRECT, 0);
        tick();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        chk("rs_redirect0", F_REDIRECT, 0);
        chk("rs_insvc0",    F_INSVC,    0);
        chk("rs_cause0",    F_CAUSE,    0);
        chk("rs_saved0",    F_SAVED,    0);
        chk("rs_count0",    F_COUNT,    0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rs_no_pending", F_REDIRECT, 0);
            tick();
        end

        @(negedge Clock);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d queued checks required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/escalonador_interrupcoes.md
# escalonador_interrupcoes

Interrupt controller and preemption scheduler for the single-cycle MIPS core. It owns the programmable quantum timer and latches three interrupt sources: halt, timer expiry and PS/2 key-ready. It arbitrates them by fixed priority and redirects the PC to the kernel vector, saving the interrupted PC. On the handler's return instruction it restores the saved PC. It sits between the control unit, the PS/2 input path and the PC next-address mux, driving the final PC selection.

## Interface
- VECTOR, 11'd0, kernel handler address driven on redirect
- PC_W, 11, PC width
- TIMER_W, 16, quantum timer width
- Clock  in  1  CPU clock; all state updates on posedge
- Reset  in  1  synchronous, active-low
- Halt  in  1  halt instruction executing this cycle
- SetClock  in  1  load quantum from Quantum
- Quantum  in  TIMER_W  quantum in cycles (Instrucao[15:0]); 0 disarms the timer
- KeyReady  in  1  one-cycle pulse, PS/2 byte available
- MaskWrite  in  1  load MaskData into Mask
- MaskData  in  2  {key_en, timer_en}
- GetInterruption  in  1  handler reads Cause this cycle
- Resume  in  1  return-from-interrupt instruction executing
- NextPC  in  PC_W  next-address mux output for the current instruction
- Redirect  out  1  override PC next value with TargetPC
- TargetPC  out  PC_W  VECTOR on dispatch, SavedPC on resume
- SavedPC  out  PC_W  interrupted return address
- Cause  out  32  0 none, 1 timer, 2 halt, 3 key
- InService  out  1  handler running
- TimerCount  out  TIMER_W  current down-counter (debug/display)

## Operation
- Registers: Pending[2:0] {halt, key, timer}, Mask[1:0], Reload, TimerCount, Armed, SavedPC, Cause, and the FSM state.
- Events: Ev = Pending | {Halt, KeyReady, 1'b0}.
- Eligibility: Elig = {Ev[2], Ev[1]&Mask[1], Ev[0]&Mask[0]}. Halt is unmaskable.
- Priority: halt > timer > key.
- FSM has two states: IDLE and SERVICE.
- IDLE, Elig≠0:
  - Redirect=1, TargetPC=VECTOR, combinational in the same cycle.
  - At the edge: SavedPC<=NextPC; Cause<=code of the winner; the winner's Pending bit clears; the losers stay latched; state<=SERVICE.
- IDLE, Elig=0: Redirect=0. Masked events latch into Pending.
- SERVICE:
  - All events latch into Pending; none dispatch; the timer is frozen.
  - GetInterruption=1: Cause<=0 at the edge. The instruction reads the pre-edge Cause value.
  - Resume=1: Redirect=1, TargetPC=SavedPC. At the edge: state<=IDLE and TimerCount<=Reload if Armed.
- Timer:
  - SetClock: Reload<=Quantum, TimerCount<=Quantum, Armed<=(Quantum≠0).
  - Otherwise, when Armed, IDLE and no dispatch this cycle: TimerCount decrements.
  - Expiry: when TimerCount==1, Pending[0]<=1 and TimerCount<=Reload (auto-reload, no wrap below 1).
- Mask: MaskWrite loads Mask at the edge. Clearing a mask bit does not clear Pending.
- Mode: InService = (state==SERVICE).

## Timing
- Reset (Reset=0 at an edge):
  - state=IDLE, Pending=0, Mask=2'b11, Reload=0, TimerCount=0, Armed=0, SavedPC=0, Cause=0.
  - Redirect=0, InService=0.
  - Takes effect mid-service too; held events are discarded.
- Latency:
  - Halt/KeyReady at cycle t (IDLE, eligible): Redirect in t, PC=VECTOR in t+1.
  - Timer expiry edge at end of t: Redirect in t+1.
- Simultaneous events:
  - Halt+timer: halt wins, timer stays pending and dispatches on the first IDLE cycle after Resume.
  - SetClock with expiry: SetClock wins, no pending set.
  - Resume and GetInterruption together: both act.
  - Resume with Pending≠0: return Redirect this cycle, re-dispatch next cycle with SavedPC<=NextPC (=old SavedPC+1 path as computed by the core).
- Resume or GetInterruption in IDLE: ignored.

## Test plan
- Timer: reset; SetClock Quantum=5; no events -> Pending[0] set at 5th edge, Redirect=1 next cycle with TargetPC=0; SavedPC=NextPC; Cause=1; TimerCount reloads to 5.
- Halt with timer due same cycle -> Cause=2; after Resume (TargetPC=SavedPC) the next cycle redirects with Cause=1.
- Mask: MaskData=2'b01, KeyReady pulse -> no Redirect, Pending[1]=1; then MaskData=2'b11 -> Redirect next cycle, Cause=3.
- Service: in SERVICE, 20 cycles elapse -> TimerCount unchanged, KeyReady only latches, Redirect=0; GetInterruption -> Cause reads prior code, then 0.
- Reset low during SERVICE with Pending=3'b011 -> next cycle all outputs at reset values, no Redirect.
- Quantum=0 -> Armed=0; no timer interrupt in 1000 cycles.
